// File: rtl/gemm_insn_dispatch.sv
// gemm_insn_dispatch
// Upstream stage of the gemm core. Buffers 128-bit VTA instructions in a small
// FIFO and presents one GEMM instruction at a time to the gemm block using an
// ap_start / ap_ready / ap_done handshake. FINISH instructions are consumed
// locally and produce a one-cycle pulse. Any other opcode is dropped and
// raises a sticky illegal flag.
//
// Ports:
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   s_insn_data/valid     incoming instruction stream
//   s_insn_ready          FIFO has room; derived from the registered count only
//   insn                  instruction presented to gemm, stable from START to done
//   gemm_ap_start         start request, held until gemm_ap_ready is sampled
//   gemm_ap_ready/done    gemm handshake inputs
//   busy                  dispatcher not idle or FIFO non-empty
//   finish                one-cycle pulse per FINISH instruction
//   illegal_insn          sticky, set by any non-GEMM/non-FINISH opcode
//   fifo_count            FIFO occupancy
//
// Optional build macro GEMM_DISPATCH_STATS_EN adds three saturating 32-bit
// counters: stat_gemm_cnt, stat_stall_cnt, stat_busy_cnt.
module gemm_insn_dispatch #(
  parameter int         INS_WIDTH     = 128,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         PTR_WIDTH     = 2,
  parameter logic [2:0] GEMM_OPCODE   = 3'd2,
  parameter logic [2:0] FINISH_OPCODE = 3'd3
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [INS_WIDTH-1:0] s_insn_data,
  input  logic                 s_insn_valid,
  output logic                 s_insn_ready,
  output logic [INS_WIDTH-1:0] insn,
  output logic                 gemm_ap_start,
  input  logic                 gemm_ap_ready,
  input  logic                 gemm_ap_done,
  output logic                 busy,
  output logic                 finish,
  output logic                 illegal_insn,
  output logic [PTR_WIDTH:0]   fifo_count
`ifdef GEMM_DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_gemm_cnt,
  output logic [31:0]          stat_stall_cnt,
  output logic [31:0]          stat_busy_cnt
`endif
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] ZERO_C  = (PTR_WIDTH+1)'(0);
  localparam logic [PTR_WIDTH:0] ONE_C   = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE_C = PTR_WIDTH'(1);

  // LAUNCH is the cycle between popping a GEMM and raising ap_start; it gives
  // the fixed two-edge push-to-start and done-to-next-start latency.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  logic [INS_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_r;
  logic [PTR_WIDTH-1:0] rd_ptr_r;
  logic [PTR_WIDTH:0]   count_r;
  state_t               state_r;
  state_t               state_s;
  logic                 push_s;
  logic                 pop_s;
  logic [INS_WIDTH-1:0] head_s;
  logic [2:0]           head_op_s;
  logic [INS_WIDTH-1:0] insn_r;
  logic                 start_r;
  logic                 finish_r;
  logic                 illegal_r;

  assign s_insn_ready  = (count_r != DEPTH_C);
  assign push_s        = s_insn_valid && s_insn_ready;
  assign head_s        = mem_r[rd_ptr_r];
  assign head_op_s     = head_s[2:0];
  assign insn          = insn_r;
  assign gemm_ap_start = start_r;
  assign finish        = finish_r;
  assign illegal_insn  = illegal_r;
  assign fifo_count    = count_r;
  assign busy          = (state_r != ST_IDLE) || (count_r != ZERO_C);

  // FIFO storage write; contents need no reset because count gates every read.
  always_ff @(posedge ap_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_insn_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Next-state logic and pop decision; at most one pop per idle cycle.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != ZERO_C) begin
          pop_s = 1'b1;
          if (head_op_s == GEMM_OPCODE) begin
            state_s = ST_LAUNCH;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_s = ST_START;
      ST_START: begin
        if (gemm_ap_ready) begin
          if (gemm_ap_done) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_WAIT: begin
        if (gemm_ap_done) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs: instruction latch, start request, finish pulse, illegal flag.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      insn_r    <= '0;
      start_r   <= 1'b0;
      finish_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      if (pop_s) begin
        insn_r <= head_s;
      end
      // start mirrors the START state so it drops on the edge leaving START
      start_r  <= (state_s == ST_START);
      finish_r <= pop_s && (head_op_s == FINISH_OPCODE);
      if (pop_s && (head_op_s != GEMM_OPCODE) && (head_op_s != FINISH_OPCODE)) begin
        illegal_r <= 1'b1;
      end
    end
  end

`ifdef GEMM_DISPATCH_STATS_EN
  logic [31:0] stat_gemm_r;
  logic [31:0] stat_stall_r;
  logic [31:0] stat_busy_r;

  assign stat_gemm_cnt  = stat_gemm_r;
  assign stat_stall_cnt = stat_stall_r;
  assign stat_busy_cnt  = stat_busy_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Saturating activity counters.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stat_gemm_r  <= 32'd0;
      stat_stall_r <= 32'd0;
      stat_busy_r  <= 32'd0;
    end else begin
      if ((state_s == ST_START) && (state_r != ST_START)) begin
        stat_gemm_r <= sat_inc(stat_gemm_r);
      end
      if (s_insn_valid && !s_insn_ready) begin
        stat_stall_r <= sat_inc(stat_stall_r);
      end
      if ((state_r == ST_START) || (state_r == ST_WAIT)) begin
        stat_busy_r <= sat_inc(stat_busy_r);
      end
    end
  end
`endif

endmodule
